// File: rtl/nx_fifo_rd_serdes.sv
// Read-side serialiser: pops WIDTH-bit words from an nx_fifo and streams them out LSB chunk first.
// Optional statistics counters are built when NX_FIFO_RD_SERDES_STATS_EN is defined.
module nx_fifo_rd_serdes #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_underflow,
  output logic                 fifo_ren,
  output logic                 fifo_clear,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 rd_err,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam int unsigned RATIO = WIDTH / OUT_WIDTH;
  localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [BW-1:0]    r_beat_cnt;
  logic             r_rd_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic [BW-1:0]    w_beat_nxt;
  logic             w_pop;
  logic             w_valid;
  logic             w_last;
  logic             w_hs;
  logic [WIDTH-1:0] w_shifted;

  assign w_valid   = (r_state == S_BUSY);
  assign w_last    = (r_beat_cnt == LAST_BEAT);
  assign w_hs      = w_valid & out_ready;
  assign w_shifted = r_hold >> (32'(r_beat_cnt) * OUT_WIDTH);

  // State register and held word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_beat_cnt <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rd_err   <= r_rd_err | fifo_underflow;
    end
  end

  // Next state, pop decision and beat sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_beat_nxt  = r_beat_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_pop       = 1'b1;
          w_hold_nxt  = fifo_rdata;
          w_beat_nxt  = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_hs) begin
          if (!w_last) begin
            w_beat_nxt = r_beat_cnt + BW'(1);
          end else if (!fifo_empty) begin
            // Reload on the last accepted beat keeps the stream bubble-free
            w_pop      = 1'b1;
            w_hold_nxt = fifo_rdata;
            w_beat_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
        w_beat_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
        w_beat_nxt  = '0;
      end
    endcase
    // Flush outranks any pop or handshake; an accepted beat this cycle is dropped
    if (flush) begin
      w_pop       = 1'b0;
      w_state_nxt = S_FLUSH;
      w_hold_nxt  = '0;
      w_beat_nxt  = '0;
    end
  end

  assign fifo_ren   = w_pop & ~rst;
  assign fifo_clear = (r_state == S_FLUSH) & ~rst;
  assign out_valid  = w_valid;
  assign out_last   = w_valid & w_last;
  assign out_data   = w_valid ? w_shifted[OUT_WIDTH-1:0] : '0;
  assign rd_err     = r_rd_err;

`ifdef NX_FIFO_RD_SERDES_STATS_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Saturating pop and stall counters; flush leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fifo_ren && (r_word_cnt != '1)) begin
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end
      if (w_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign word_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_serdes.sv
// Scoreboard bench for nx_fifo_rd_serdes: a RATIO=4 instance and a RATIO=1 instance, each fed by a FIFO model.
module tb_nx_fifo_rd_serdes;

`ifdef NX_FIFO_RD_SERDES_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RATIO=4 instance
  logic         f_empty, f_unf, f_ren, f_clr, flush;
  logic [127:0] f_rdata;
  logic         o_valid, o_ready, o_last, rd_err;
  logic [31:0]  o_data, word_cnt, stall_cnt;

  // RATIO=1 instance
  logic         b_empty, b_unf, b_ren, b_clr, b_flush;
  logic [127:0] b_rdata;
  logic         b_valid, b_ready, b_last, b_err;
  logic [127:0] b_data;
  logic [31:0]  b_wcnt, b_scnt;

  nx_fifo_rd_serdes #(.WIDTH(128), .OUT_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(f_empty), .fifo_rdata(f_rdata),
    .fifo_underflow(f_unf), .fifo_ren(f_ren), .fifo_clear(f_clr), .flush(flush),
    .out_valid(o_valid), .out_ready(o_ready), .out_data(o_data), .out_last(o_last),
    .rd_err(rd_err), .word_cnt(word_cnt), .stall_cnt(stall_cnt)
  );

  nx_fifo_rd_serdes #(.WIDTH(128), .OUT_WIDTH(128), .CNT_WIDTH(32)) u_dut_r1 (
    .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rdata(b_rdata),
    .fifo_underflow(b_unf), .fifo_ren(b_ren), .fifo_clear(b_clr), .flush(b_flush),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_last(b_last),
    .rd_err(b_err), .word_cnt(b_wcnt), .stall_cnt(b_scnt)
  );

  int unsigned  n_chk = 0;
  int unsigned  n_fail = 0;
  int unsigned  ren_cnt = 0;
  int unsigned  b_ren_cnt = 0;
  logic [127:0] q[$];
  logic [127:0] b_q[$];
  logic [32:0]  exp_q[$];
  logic [127:0] b_exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_main();
    f_empty = (q.size() == 0);
    f_rdata = (q.size() == 0) ? 128'd0 : q[0];
  endtask

  task automatic upd_b();
    b_empty = (b_q.size() == 0);
    b_rdata = (b_q.size() == 0) ? 128'd0 : b_q[0];
  endtask

  task automatic push_word(input logic [127:0] w, input bit track);
    q.push_back(w);
    upd_main();
    if (track) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), w[k*32 +: 32]});
    end
  endtask

  task automatic push_b(input logic [127:0] w);
    b_q.push_back(w);
    upd_b();
    b_exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_done", 128'(n < max_cyc), 128'd1);
  endtask

  // FIFO models: sample strobes at the edge, update contents just after it
  always @(posedge clk) begin
    bit ren_s, clr_s;
    ren_s = f_ren;
    clr_s = f_clr;
    #1;
    if (clr_s) q.delete();
    else if (ren_s) begin
      chk("ren_while_empty", 128'(q.size() == 0), 128'd0);
      if (q.size() != 0) void'(q.pop_front());
      ren_cnt++;
    end
    upd_main();
  end

  always @(posedge clk) begin
    bit ren_s, clr_s;
    ren_s = b_ren;
    clr_s = b_clr;
    #1;
    if (clr_s) b_q.delete();
    else if (ren_s) begin
      chk("r1_ren_while_empty", 128'(b_q.size() == 0), 128'd0);
      if (b_q.size() != 0) void'(b_q.pop_front());
      b_ren_cnt++;
    end
    upd_b();
  end

  // Output monitors at the falling edge
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && !flush) begin
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 128'(o_data), 128'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(o_data), 128'(e[31:0]));
          chk("beat_last", 128'(o_last), 128'(e[32]));
        end
      end else if (!o_valid) begin
        chk("idle_outputs_zero", 128'({o_last, o_data}), 128'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      if (b_valid && b_ready) begin
        if (b_exp_q.size() == 0) chk("r1_unexpected_beat", b_data, 128'd0);
        else begin
          e = b_exp_q.pop_front();
          chk("r1_beat_data", b_data, e);
          chk("r1_beat_last", 128'(b_last), 128'd1);
        end
      end
      if (b_ren && b_valid) chk("r1_ren_on_accept", 128'(b_ready), 128'd1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    int unsigned  r0, s0;
    rst = 1'b1; f_unf = 1'b0; flush = 1'b0; o_ready = 1'b1;
    b_unf = 1'b0; b_flush = 1'b0; b_ready = 1'b1;
    upd_main(); upd_b();
    repeat (3) step();
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_data", 128'({o_last, o_data}), 128'd0);
    chk("rst_ren_clr", 128'({f_ren, f_clr}), 128'd0);
    chk("rst_rd_err", 128'(rd_err), 128'd0);
    chk("rst_counters", 128'({word_cnt, stall_cnt}), 128'd0);
    rst = 1'b0;
    step();

    // Single word, consecutive beats
    r0 = ren_cnt;
    push_word(128'h33333333_22222222_11111111_00000000, 1'b1);
    #1;
    chk("t1_ren_comb", 128'(f_ren), 128'd1);
    step();
    chk("t1_latency_valid", 128'(o_valid), 128'd1);
    chk("t1_first_beat", 128'(o_data), 128'd0);
    repeat (4) step();
    chk("t1_idle_after", 128'(o_valid), 128'd0);
    chk("t1_all_beats", 128'(exp_q.size()), 128'd0);
    chk("t1_ren_count", 128'(ren_cnt - r0), 128'd1);

    // Three words back-to-back
    r0 = ren_cnt;
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      push_word(w, 1'b1);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      chk("b2b_valid", 128'(o_valid), 128'd1);
      chk("b2b_ren", 128'(f_ren), 128'(i == 3 || i == 7));
      step();
    end
    chk("b2b_idle_after", 128'(o_valid), 128'd0);
    chk("b2b_all_beats", 128'(exp_q.size()), 128'd0);
    chk("b2b_ren_count", 128'(ren_cnt - r0), 128'd3);

    // Backpressure on beat 2
    push_word(128'h33333333_22222222_11111111_00000000, 1'b1);
    repeat (3) step();
    o_ready = 1'b0;
    s0 = stall_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(o_valid), 128'd1);
      chk("bp_data_hold", 128'(o_data), 128'h22222222);
      chk("bp_last_hold", 128'(o_last), 128'd0);
      step();
    end
    chk("bp_stall_cnt", 128'(stall_cnt - s0), STATS ? 128'd5 : 128'd0);
    o_ready = 1'b1;
    drain(20);

    // Flush from IDLE with a word waiting: no pop
    r0 = ren_cnt;
    push_word(128'hdead, 1'b0);
    flush = 1'b1;
    #1;
    chk("fi_no_ren", 128'(f_ren), 128'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fi_clear", 128'(f_clr), 128'd1);
    step();
    chk("fi_fifo_cleared", 128'(f_empty), 128'd1);
    chk("fi_ren_count", 128'(ren_cnt - r0), 128'd0);

    // Flush mid-word with two words still queued
    r0 = ren_cnt;
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      push_word(w, 1'b1);
    end
    step();
    step();
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    #1;
    chk("fl_clear_pulse", 128'(f_clr), 128'd1);
    chk("fl_valid_low", 128'(o_valid), 128'd0);
    chk("fl_no_ren", 128'(f_ren), 128'd0);
    step();
    chk("fl_clear_single", 128'(f_clr), 128'd0);
    chk("fl_fifo_cleared", 128'(f_empty), 128'd1);
    repeat (3) begin
      chk("fl_stays_idle", 128'(o_valid), 128'd0);
      step();
    end
    chk("fl_ren_count", 128'(ren_cnt - r0), 128'd1);
    chk("word_cnt_total", 128'(word_cnt), STATS ? 128'(ren_cnt) : 128'd0);

    // Underflow sets a sticky error; reset mid-word clears everything
    f_unf = 1'b1;
    step();
    f_unf = 1'b0;
    #1;
    chk("uf_rd_err_set", 128'(rd_err), 128'd1);
    repeat (3) step();
    chk("uf_rd_err_sticky", 128'(rd_err), 128'd1);
    push_word(128'h44444444_33333333_22222222_11111111, 1'b1);
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("mr_valid", 128'(o_valid), 128'd0);
    chk("mr_data", 128'({o_last, o_data}), 128'd0);
    chk("mr_rd_err", 128'(rd_err), 128'd0);
    chk("mr_word_cnt", 128'(word_cnt), 128'd0);
    chk("mr_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("mr_clear", 128'(f_clr), 128'd0);
    r0 = ren_cnt;
    push_word(128'h88888888_77777777_66666666_55555555, 1'b1);
    #1;
    chk("mr_ren_forced_low", 128'(f_ren), 128'd0);
    step();
    chk("mr_no_pop_in_rst", 128'(ren_cnt - r0), 128'd0);
    rst = 1'b0;
    drain(20);
    chk("mr_post_pop", 128'(ren_cnt - r0), 128'd1);
    chk("mr_word_cnt_after", 128'(word_cnt), STATS ? 128'd1 : 128'd0);

    // RATIO=1 instance with toggling ready
    r0 = b_ren_cnt;
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      push_b(w);
    end
    begin
      int n = 0;
      while ((b_exp_q.size() != 0 || b_valid) && n < 60) begin
        b_ready = ~b_ready;
        step();
        n++;
      end
      chk("r1_drain_done", 128'(n < 60), 128'd1);
    end
    chk("r1_ren_count", 128'(b_ren_cnt - r0), 128'd4);
    chk("r1_idle_data", b_data, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
